// File: rtl/axi_tb_pkg.sv
// Shared types for the AXI write-response slave: response codes, W-channel
// state encoding and the queue entry layouts.
package axi_tb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Queue entries carry IDs at this fixed width; narrower IDs are zero-extended.
  localparam int ID_W_MAX = 16;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_BURST = 2'd1,
    W_STALL = 2'd2
  } w_state_t;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [7:0]          len;
  } aw_entry_t;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [1:0]          resp;
  } b_entry_t;

  function automatic logic [1:0] resp_code(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_slv_wr_responder_if.sv
// AW/W/B channel bundle for the write-response slave plus its status outputs.
// Every channel transfers on a rising edge where valid && ready; valid never waits on ready.
interface axi_slv_wr_responder_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 32
);
  logic                  in_awvalid;
  logic                  out_awready;
  logic [AXI_ADDR_W-1:0] in_awaddr;
  logic [7:0]            in_awlen;
  logic [AXI_ID_W-1:0]   in_awid;
  logic                  in_wvalid;
  logic                  out_wready;
  logic                  in_wlast;
  logic [AXI_ID_W-1:0]   in_wid;
  logic [AXI_DATA_W-1:0] in_wdata;
  logic [3:0]            in_wstrb;
  logic                  out_bvalid;
  logic                  in_bready;
  logic [AXI_ID_W-1:0]   out_bid;
  logic [1:0]            out_bresp;
  logic                  out_err;
  logic [31:0]           out_wbeat_total;

  modport slave (
    input  in_awvalid, in_awaddr, in_awlen, in_awid,
    input  in_wvalid, in_wlast, in_wid, in_wdata, in_wstrb,
    input  in_bready,
    output out_awready, out_wready, out_bvalid, out_bid, out_bresp,
    output out_err, out_wbeat_total
  );

  modport master (
    output in_awvalid, in_awaddr, in_awlen, in_awid,
    output in_wvalid, in_wlast, in_wid, in_wdata, in_wstrb,
    output in_bready,
    input  out_awready, out_wready, out_bvalid, out_bid, out_bresp,
    input  out_err, out_wbeat_total
  );
endinterface

// File: rtl/tb_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head data is read combinationally.
module tb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_slv_wr_responder.sv
// AXI write slave that queues AW requests, checks/counts W beats against the
// queued burst and returns in-order B responses (SLVERR for malformed bursts).
module axi_slv_wr_responder
  import axi_tb_pkg::*;
#(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_ID_W        = 4,
  parameter int AXI_DATA_W      = 32,
  parameter int SLV_OSTDREQ_NUM = 4
) (
  input  logic                   aclk,
  input  logic                   srst,
  axi_slv_wr_responder_if.slave  bus,
  output w_state_t               w_state
);
  localparam int CW = $clog2(SLV_OSTDREQ_NUM) + 1;

  aw_entry_t aw_push_data, aw_head;
  b_entry_t  b_push_data, b_head;
  logic      aw_full, aw_empty, b_full, b_empty;
  logic [CW-1:0] aw_cnt, b_cnt, aw_cnt_nxt, b_cnt_nxt;
  logic      aw_push, aw_pop, b_push, b_pop;
  logic      w_fire, beat_final, beat_err, burst_err;
  logic [7:0] beat_cnt;
  logic      err_flag;
  logic [AXI_ID_W-1:0] head_id;
  w_state_t  state, state_nxt;
  logic      unused_bits;

  assign bus.out_awready = !aw_full && !srst;
  assign aw_push      = bus.in_awvalid && bus.out_awready;
  assign aw_push_data = '{id: ID_W_MAX'(bus.in_awid), len: bus.in_awlen};

  tb_sync_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_aw_q (
    .clk(aclk), .srst(srst), .push(aw_push), .push_data(aw_push_data),
    .pop(aw_pop), .pop_data(aw_head), .full(aw_full), .empty(aw_empty), .count(aw_cnt)
  );

  assign head_id        = aw_head.id[AXI_ID_W-1:0];
  assign bus.out_wready = (state == W_BURST) && !srst;
  assign w_fire         = bus.in_wvalid && bus.out_wready;
  assign beat_final     = (beat_cnt == aw_head.len);
  assign beat_err       = (bus.in_wid != head_id) || (bus.in_wlast != beat_final) ||
                          (bus.in_wstrb == 4'b0000);
  assign burst_err      = err_flag || beat_err;

  // The burst length comes from AW only; wlast is checked but never ends a burst.
  assign aw_pop      = w_fire && beat_final;
  assign b_push      = aw_pop;
  assign b_push_data = '{id: aw_head.id, resp: resp_code(burst_err)};
  assign b_pop       = bus.out_bvalid && bus.in_bready;

  tb_sync_fifo #(.WIDTH($bits(b_entry_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_b_q (
    .clk(aclk), .srst(srst), .push(b_push), .push_data(b_push_data),
    .pop(b_pop), .pop_data(b_head), .full(b_full), .empty(b_empty), .count(b_cnt)
  );

  assign bus.out_bvalid = !b_empty;
  assign bus.out_bid    = b_empty ? '0 : b_head.id[AXI_ID_W-1:0];
  assign bus.out_bresp  = b_empty ? 2'b00 : b_head.resp;

  assign aw_cnt_nxt = aw_cnt + CW'(aw_push) - CW'(aw_pop);
  assign b_cnt_nxt  = b_cnt + CW'(b_push) - CW'(b_pop);

  always_ff @(posedge aclk) begin
    if (srst) state <= W_IDLE;
    else      state <= state_nxt;
  end

  // State tracks next-cycle occupancy so an AW into an empty queue opens W one cycle later.
  always_comb begin
    state_nxt = W_IDLE;
    if (aw_cnt_nxt != '0) begin
      if (b_cnt_nxt == CW'(SLV_OSTDREQ_NUM)) state_nxt = W_STALL;
      else                                   state_nxt = W_BURST;
    end
  end

  assign w_state = state;

  always_ff @(posedge aclk) begin
    if (srst) begin
      beat_cnt            <= '0;
      err_flag            <= 1'b0;
      bus.out_err         <= 1'b0;
      bus.out_wbeat_total <= '0;
    end else begin
      bus.out_err <= aw_pop && burst_err;
      if (w_fire) begin
        bus.out_wbeat_total <= bus.out_wbeat_total + 32'd1;
        if (beat_final) begin
          beat_cnt <= '0;
          err_flag <= 1'b0;
        end else begin
          beat_cnt <= beat_cnt + 8'd1;
          err_flag <= burst_err;
        end
      end
    end
  end

  assign unused_bits = ^{bus.in_awaddr, bus.in_wdata, aw_empty, b_full, aw_head, b_head};

endmodule

// File: tb/tb_axi_slv_wr_responder.sv
// Directed bench for axi_slv_wr_responder: AW/W/B sequencing, error marking,
// queue back-pressure, long bursts and mid-burst reset.
module tb_axi_slv_wr_responder;
  import axi_tb_pkg::*;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_DATA_W = 32;
  localparam int DEPTH      = 4;

  logic     aclk = 1'b0;
  logic     srst;
  w_state_t w_state;
  int       n_pass  = 0;
  int       n_total = 0;
  logic [5:0] exp_q[$];

  axi_slv_wr_responder_if #(.AXI_ADDR_W(AXI_ADDR_W), .AXI_ID_W(AXI_ID_W),
                            .AXI_DATA_W(AXI_DATA_W)) bus ();

  axi_slv_wr_responder #(
    .AXI_ADDR_W(AXI_ADDR_W), .AXI_ID_W(AXI_ID_W), .AXI_DATA_W(AXI_DATA_W),
    .SLV_OSTDREQ_NUM(DEPTH)
  ) dut (
    .aclk(aclk), .srst(srst), .bus(bus), .w_state(w_state)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (start and end just after a negedge) ----------------
  task automatic drive_idle();
    bus.in_awvalid = 1'b0; bus.in_awaddr = '0; bus.in_awlen = '0; bus.in_awid = '0;
    bus.in_wvalid = 1'b0; bus.in_wlast = 1'b0; bus.in_wid = '0; bus.in_wdata = '0;
    bus.in_wstrb = 4'h0;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    srst = 1'b1; drive_idle(); bus.in_bready = 1'b0;
    repeat (2) @(negedge aclk);
    srst = 1'b0;
    #1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [7:0] len);
    int waited = 0;
    bus.in_awvalid = 1'b1; bus.in_awid = id; bus.in_awlen = len; bus.in_awaddr = $urandom;
    #1;
    while (!bus.out_awready && waited < 100) begin
      @(negedge aclk); #1; waited++;
    end
    n_total++;
    if (bus.out_awready !== 1'b1) $display("FAIL aw_timeout: awready=%0b required 1", bus.out_awready);
    else n_pass++;
    @(negedge aclk);
    bus.in_awvalid = 1'b0;
    #1;
  endtask

  task automatic w_beat(input logic [3:0] id, input logic last, input logic [3:0] strb);
    int waited = 0;
    bus.in_wvalid = 1'b1; bus.in_wid = id; bus.in_wlast = last; bus.in_wstrb = strb;
    bus.in_wdata = $urandom;
    #1;
    while (!bus.out_wready && waited < 100) begin
      @(negedge aclk); #1; waited++;
    end
    n_total++;
    if (bus.out_wready !== 1'b1) $display("FAIL w_timeout: wready=%0b required 1", bus.out_wready);
    else n_pass++;
    @(negedge aclk);
    bus.in_wvalid = 1'b0; bus.in_wlast = 1'b0;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge aclk);
    srst = 1'b1; drive_idle(); bus.in_bready = 1'b0; bus.in_awvalid = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    n_total++; if (bus.out_awready !== 1'b0) $display("FAIL rst_awready: got %0b exp 0", bus.out_awready); else n_pass++;
    n_total++; if (bus.out_wready !== 1'b0) $display("FAIL rst_wready: got %0b exp 0", bus.out_wready); else n_pass++;
    n_total++; if (bus.out_bvalid !== 1'b0) $display("FAIL rst_bvalid: got %0b exp 0", bus.out_bvalid); else n_pass++;
    n_total++; if (bus.out_bid !== 4'h0) $display("FAIL rst_bid: got %0h exp 0", bus.out_bid); else n_pass++;
    n_total++; if (bus.out_bresp !== 2'b00) $display("FAIL rst_bresp: got %0b exp 00", bus.out_bresp); else n_pass++;
    n_total++; if (bus.out_err !== 1'b0) $display("FAIL rst_err: got %0b exp 0", bus.out_err); else n_pass++;
    n_total++; if (bus.out_wbeat_total !== 32'd0) $display("FAIL rst_wbeat_total: got %0d exp 0", bus.out_wbeat_total); else n_pass++;
    n_total++; if (w_state !== W_IDLE) $display("FAIL rst_state: got %0d exp %0d", w_state, W_IDLE); else n_pass++;
    srst = 1'b0; bus.in_awvalid = 1'b0;
    #1;
    n_total++; if (bus.out_awready !== 1'b1) $display("FAIL rst_release_awready: got %0b exp 1", bus.out_awready); else n_pass++;
  endtask

  task automatic test_basic();
    apply_reset();
    bus.in_bready = 1'b1;
    aw_send(4'h5, 8'd3);
    n_total++; if (w_state !== W_BURST) $display("FAIL basic_state_after_aw: got %0d exp %0d", w_state, W_BURST); else n_pass++;
    n_total++; if (bus.out_wready !== 1'b1) $display("FAIL basic_wready_after_aw: got %0b exp 1", bus.out_wready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      w_beat(4'h5, (i == 3), 4'hF);
      if (i == 2) begin
        n_total++; if (bus.out_bvalid !== 1'b0) $display("FAIL basic_bvalid_early: got %0b exp 0", bus.out_bvalid); else n_pass++;
      end
    end
    n_total++; if (bus.out_bvalid !== 1'b1) $display("FAIL basic_bvalid: got %0b exp 1", bus.out_bvalid); else n_pass++;
    n_total++; if (bus.out_bid !== 4'h5) $display("FAIL basic_bid: got %0h exp 5", bus.out_bid); else n_pass++;
    n_total++; if (bus.out_bresp !== RESP_OKAY) $display("FAIL basic_bresp: got %0b exp 00", bus.out_bresp); else n_pass++;
    n_total++; if (bus.out_err !== 1'b0) $display("FAIL basic_err: got %0b exp 0", bus.out_err); else n_pass++;
    n_total++; if (bus.out_wbeat_total !== 32'd4) $display("FAIL basic_wbeat_total: got %0d exp 4", bus.out_wbeat_total); else n_pass++;
    @(negedge aclk); #1;
    n_total++; if (bus.out_bvalid !== 1'b0) $display("FAIL basic_bvalid_popped: got %0b exp 0", bus.out_bvalid); else n_pass++;
  endtask

  task automatic test_wlast_err();
    apply_reset();
    aw_send(4'h5, 8'd3);
    w_beat(4'h5, 1'b0, 4'hF);
    w_beat(4'h5, 1'b0, 4'hF);
    w_beat(4'h5, 1'b1, 4'hF);
    n_total++; if (bus.out_bvalid !== 1'b0) $display("FAIL wlast_no_early_end: bvalid got %0b exp 0", bus.out_bvalid); else n_pass++;
    n_total++; if (bus.out_wready !== 1'b1) $display("FAIL wlast_still_burst: wready got %0b exp 1", bus.out_wready); else n_pass++;
    w_beat(4'h5, 1'b1, 4'hF);
    n_total++; if (bus.out_bvalid !== 1'b1) $display("FAIL wlast_bvalid: got %0b exp 1", bus.out_bvalid); else n_pass++;
    n_total++; if (bus.out_bresp !== RESP_SLVERR) $display("FAIL wlast_bresp: got %0b exp 10", bus.out_bresp); else n_pass++;
    n_total++; if (bus.out_bid !== 4'h5) $display("FAIL wlast_bid: got %0h exp 5", bus.out_bid); else n_pass++;
    n_total++; if (bus.out_err !== 1'b1) $display("FAIL wlast_err_pulse: got %0b exp 1", bus.out_err); else n_pass++;
    n_total++; if (bus.out_wbeat_total !== 32'd4) $display("FAIL wlast_wbeat_total: got %0d exp 4", bus.out_wbeat_total); else n_pass++;
    @(negedge aclk); #1;
    n_total++; if (bus.out_err !== 1'b0) $display("FAIL wlast_err_once: got %0b exp 0", bus.out_err); else n_pass++;
    n_total++; if (bus.out_bresp !== RESP_SLVERR) $display("FAIL wlast_bresp_held: got %0b exp 10", bus.out_bresp); else n_pass++;
    bus.in_bready = 1'b1;
    @(negedge aclk); #1;
    n_total++; if (bus.out_bvalid !== 1'b0) $display("FAIL wlast_bvalid_popped: got %0b exp 0", bus.out_bvalid); else n_pass++;
  endtask

  task automatic test_wrong_id();
    apply_reset();
    aw_send(4'h5, 8'd1);
    w_beat(4'h6, 1'b0, 4'hF);
    w_beat(4'h5, 1'b1, 4'hF);
    n_total++; if (bus.out_bid !== 4'h5) $display("FAIL wid_bid: got %0h exp 5", bus.out_bid); else n_pass++;
    n_total++; if (bus.out_bresp !== RESP_SLVERR) $display("FAIL wid_bresp: got %0b exp 10", bus.out_bresp); else n_pass++;
    n_total++; if (bus.out_err !== 1'b1) $display("FAIL wid_err: got %0b exp 1", bus.out_err); else n_pass++;
    bus.in_bready = 1'b1;
    @(negedge aclk); #1;
  endtask

  task automatic test_bq_stall();
    logic [5:0] exp;
    apply_reset();
    exp_q.delete();
    for (int i = 1; i <= 4; i++) aw_send(4'(i), 8'd0);
    n_total++; if (bus.out_awready !== 1'b0) $display("FAIL stall_awready_full: got %0b exp 0", bus.out_awready); else n_pass++;
    for (int i = 1; i <= 4; i++) exp_q.push_back({4'(i), RESP_OKAY});
    w_beat(4'h1, 1'b1, 4'hF);
    n_total++; if (bus.out_awready !== 1'b1) $display("FAIL stall_awready_reopen: got %0b exp 1", bus.out_awready); else n_pass++;
    aw_send(4'h5, 8'd0);
    for (int i = 2; i <= 4; i++) w_beat(4'(i), 1'b1, 4'hF);
    n_total++; if (w_state !== W_STALL) $display("FAIL stall_state: got %0d exp %0d", w_state, W_STALL); else n_pass++;
    n_total++; if (bus.out_wready !== 1'b0) $display("FAIL stall_wready: got %0b exp 0", bus.out_wready); else n_pass++;
    bus.in_wvalid = 1'b1; bus.in_wid = 4'h5; bus.in_wlast = 1'b1; bus.in_wstrb = 4'hF;
    repeat (3) @(negedge aclk);
    #1;
    n_total++; if (bus.out_wbeat_total !== 32'd4) $display("FAIL stall_no_accept: wbeat_total got %0d exp 4", bus.out_wbeat_total); else n_pass++;
    bus.in_wvalid = 1'b0; bus.in_wlast = 1'b0;
    bus.in_bready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      n_total++;
      if (bus.out_bvalid !== 1'b1 || {bus.out_bid, bus.out_bresp} !== exp)
        $display("FAIL stall_drain_%0d: bvalid=%0b id/resp=%h exp valid 1 id/resp=%h", k, bus.out_bvalid, {bus.out_bid, bus.out_bresp}, exp);
      else n_pass++;
      @(negedge aclk); #1;
    end
    n_total++; if (bus.out_bvalid !== 1'b0) $display("FAIL stall_drained: bvalid got %0b exp 0", bus.out_bvalid); else n_pass++;
    n_total++; if (w_state !== W_BURST) $display("FAIL stall_resume_state: got %0d exp %0d", w_state, W_BURST); else n_pass++;
    w_beat(4'h5, 1'b1, 4'hF);
    n_total++; if ({bus.out_bvalid, bus.out_bid, bus.out_bresp} !== {1'b1, 4'h5, RESP_OKAY})
      $display("FAIL stall_fifth_b: valid/id/resp=%h exp %h", {bus.out_bvalid, bus.out_bid, bus.out_bresp}, {1'b1, 4'h5, RESP_OKAY});
    else n_pass++;
    n_total++; if (bus.out_wbeat_total !== 32'd5) $display("FAIL stall_wbeat_total: got %0d exp 5", bus.out_wbeat_total); else n_pass++;
    @(negedge aclk); #1;
  endtask

  task automatic test_len255();
    apply_reset();
    bus.in_bready = 1'b1;
    aw_send(4'h9, 8'd255);
    for (int i = 0; i < 256; i++) begin
      w_beat(4'h9, (i == 255), 4'hF);
      if (i == 254) begin
        n_total++; if (bus.out_bvalid !== 1'b0) $display("FAIL len255_early_b: bvalid got %0b exp 0", bus.out_bvalid); else n_pass++;
      end
    end
    n_total++; if (bus.out_bvalid !== 1'b1) $display("FAIL len255_bvalid: got %0b exp 1", bus.out_bvalid); else n_pass++;
    n_total++; if (bus.out_bid !== 4'h9) $display("FAIL len255_bid: got %0h exp 9", bus.out_bid); else n_pass++;
    n_total++; if (bus.out_bresp !== RESP_OKAY) $display("FAIL len255_bresp: got %0b exp 00", bus.out_bresp); else n_pass++;
    n_total++; if (bus.out_wbeat_total !== 32'd256) $display("FAIL len255_wbeat_total: got %0d exp 256", bus.out_wbeat_total); else n_pass++;
    n_total++; if (w_state !== W_IDLE) $display("FAIL len255_state: got %0d exp %0d", w_state, W_IDLE); else n_pass++;
    @(negedge aclk); #1;
    aw_send(4'h3, 8'd0);
    w_beat(4'h3, 1'b1, 4'hF);
    n_total++; if ({bus.out_bvalid, bus.out_bid, bus.out_bresp} !== {1'b1, 4'h3, RESP_OKAY})
      $display("FAIL len255_counter_wrap: valid/id/resp=%h exp %h", {bus.out_bvalid, bus.out_bid, bus.out_bresp}, {1'b1, 4'h3, RESP_OKAY});
    else n_pass++;
    @(negedge aclk); #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    aw_send(4'h2, 8'd0);
    w_beat(4'h2, 1'b1, 4'hF);
    aw_send(4'h5, 8'd7);
    w_beat(4'h5, 1'b0, 4'hF);
    w_beat(4'h5, 1'b0, 4'hF);
    bus.in_wvalid = 1'b1; bus.in_wid = 4'h5; bus.in_wlast = 1'b0; bus.in_wstrb = 4'hF;
    srst = 1'b1;
    @(negedge aclk); #1;
    n_total++; if (bus.out_awready !== 1'b0) $display("FAIL mid_awready: got %0b exp 0", bus.out_awready); else n_pass++;
    n_total++; if (bus.out_wready !== 1'b0) $display("FAIL mid_wready: got %0b exp 0", bus.out_wready); else n_pass++;
    n_total++; if (bus.out_bvalid !== 1'b0) $display("FAIL mid_bvalid: got %0b exp 0", bus.out_bvalid); else n_pass++;
    n_total++; if ({bus.out_bid, bus.out_bresp} !== 6'h00) $display("FAIL mid_bid_bresp: got %h exp 00", {bus.out_bid, bus.out_bresp}); else n_pass++;
    n_total++; if (bus.out_err !== 1'b0) $display("FAIL mid_err: got %0b exp 0", bus.out_err); else n_pass++;
    n_total++; if (bus.out_wbeat_total !== 32'd0) $display("FAIL mid_wbeat_total: got %0d exp 0", bus.out_wbeat_total); else n_pass++;
    n_total++; if (w_state !== W_IDLE) $display("FAIL mid_state: got %0d exp %0d", w_state, W_IDLE); else n_pass++;
    srst = 1'b0; drive_idle();
    @(negedge aclk); #1;
    n_total++; if (bus.out_bvalid !== 1'b0) $display("FAIL mid_discarded_b: bvalid got %0b exp 0", bus.out_bvalid); else n_pass++;
    bus.in_bready = 1'b1;
    aw_send(4'h7, 8'd0);
    w_beat(4'h7, 1'b1, 4'hF);
    n_total++; if ({bus.out_bvalid, bus.out_bid, bus.out_bresp} !== {1'b1, 4'h7, RESP_OKAY})
      $display("FAIL mid_fresh_b: valid/id/resp=%h exp %h", {bus.out_bvalid, bus.out_bid, bus.out_bresp}, {1'b1, 4'h7, RESP_OKAY});
    else n_pass++;
    n_total++; if (bus.out_wbeat_total !== 32'd1) $display("FAIL mid_fresh_total: got %0d exp 1", bus.out_wbeat_total); else n_pass++;
    @(negedge aclk); #1;
  endtask

  initial begin
    srst = 1'b1;
    bus.in_bready = 1'b0;
    drive_idle();
    test_reset();
    test_basic();
    test_wlast_err();
    test_wrong_id();
    test_bq_stall();
    test_len255();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_slv_wr_responder.md
AXI_SLV_WR_RESPONDER -- requirements
Module: axi_slv_wr_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  AXI_ADDR_W, 32, AW address width
  AXI_ID_W, 4, ID width
  AXI_DATA_W, 32, W data width
  SLV_OSTDREQ_NUM, 4, AW/B queue depth; power of 2 and at least 2
REQ-002 Ports (name, direction, width, meaning); clock and reset first:
  aclk  in  1  single clock; all logic on rising edge
  srst  in  1  synchronous active-high reset
  in_awvalid  in  1  AW valid
  out_awready  out  1  AW ready
  in_awaddr  in  AXI_ADDR_W  AW address; accepted, not stored
  in_awlen  in  8  beats minus 1
  in_awid  in  AXI_ID_W  AW ID
  in_wvalid  in  1  W valid
  out_wready  out  1  W ready
  in_wlast  in  1  W last
  in_wid  in  AXI_ID_W  W ID
  in_wdata  in  AXI_DATA_W  W data; counted, not stored
  in_wstrb  in  4  byte strobes
  out_bvalid  out  1  B valid
  in_bready  in  1  B ready
  out_bid  out  AXI_ID_W  B ID
  out_bresp  out  2  B response
  out_err  out  1  one-cycle pulse per errored burst
  out_wbeat_total  out  32  accepted W beats; wraps mod 2^32

Function
REQ-003 The AW queue SHALL be a FIFO of {id,len}; out_awready = !aw_full && !srst; push on in_awvalid && out_awready.
REQ-004 When the AW queue is full, out_awready SHALL be 0 even if a pop occurs in the same cycle.
REQ-005 W state machine states SHALL be: IDLE (AW queue empty), BURST (head AW present, B queue not full), STALL (head AW present, B queue full).
REQ-006 out_wready SHALL be 1 only in BURST; it is combinational from state; W beats are never accepted in IDLE or STALL.
REQ-007 The 8-bit beat counter SHALL increment per accepted beat; a beat is final when counter == head len (len 0..255 supported).
REQ-008 A burst SHALL be marked errored if any beat has in_wid != head id, or in_wlast != (beat is final), or in_wstrb == 0.
REQ-009 The burst SHALL always terminate on the awlen-derived final beat, regardless of in_wlast.
REQ-010 On the final beat the block SHALL pop the AW queue, push {id, resp} into the B queue, clear the counter and the error flag, and pulse out_err for one cycle (next cycle) if the burst was errored.
REQ-011 resp SHALL be OKAY (2'b00) or SLVERR (2'b10).
REQ-012 out_bvalid = !b_empty, registered; B is presented the cycle after the final W beat at the earliest.
REQ-013 out_bid and out_bresp SHALL be held stable while out_bvalid && !in_bready; pop on out_bvalid && in_bready.
REQ-014 B responses SHALL be returned in AW acceptance order; no reordering by ID.
REQ-015 Simultaneous AW push and pop, or B push and pop, SHALL leave occupancy unchanged with correct data.
REQ-016 An AW accepted while the queue is empty SHALL enable W acceptance the following cycle; no combinational AW-to-W path.
REQ-017 FIFO pointers SHALL be log2(depth)+1 bits; full/empty are derived from the MSB compare and wrap modulo 2*depth.

Reset
REQ-018 While srst=1 the following SHALL be 0: out_awready, out_wready, out_bvalid, out_bid, out_bresp, out_err, out_wbeat_total, all pointers, the counter, and the error flag; state SHALL be IDLE.
REQ-019 srst asserted mid-burst or with B pending SHALL discard all queued AW and B entries; no B is issued for discarded bursts.

Structure
REQ-020 A shared package axi_tb_pkg SHALL hold the resp codes (RESP_OKAY, RESP_SLVERR), the W state enum, and the aw_entry_t/b_entry_t structs.
REQ-021 Both queues SHALL be instances of a single sub-module tb_sync_fifo (parameters WIDTH, DEPTH; srst synchronous).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - AW len=3 id=4'h5, 4 correct beats, bready=1 -> B id=5, resp=00, one cycle after last beat; wbeat_total=4.
  - Beat 2 of len=3 carries in_wlast=1 -> burst still ends at beat 3; resp=10; out_err pulses once.
  - 5 AWs with B queue held (bready=0), depth 4 -> awready drops after 4; state STALL after 4th burst; releasing bready drains B in order.
  - len=255 burst -> exactly 256 beats accepted; counter wraps to 0; resp=00.
  - Wrong in_wid (4'h6 vs 4'h5) on beat 0 -> resp=10, bid=5.
  - srst during beat 2 of len=7 -> next cycle all outputs 0; a fresh len=0 burst afterwards -> B resp=00.
